// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared widths and types for the RAM-backed FWFT FIFO controller.
// The memory geometry here must match the ram_single_port array it drives.
package ram_fifo_ctrl_pkg;
  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_ADDR_WIDTH = 6;
  localparam int MEM_DEPTH      = 1 << MEM_ADDR_WIDTH;

  localparam int DATA_WIDTH = MEM_DATA_WIDTH;
  localparam int ADDR_WIDTH = MEM_ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH+1:0] cnt_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshakes plus the RAM-side port bundle of the FIFO controller.
// The slave modport is the controller's view; master is the surrounding system.
interface ram_fifo_ctrl_if;
  import ram_fifo_ctrl_pkg::*;

  word_t in_data;
  logic  in_valid;
  logic  in_ready;
  word_t out_data;
  logic  out_valid;
  logic  out_ready;
  cnt_t  count;
  word_t ram_data;
  addr_t ram_write_addr;
  logic  ram_we;
  addr_t ram_read_addr;
  word_t ram_q;

  modport slave (
    input  in_data, in_valid, out_ready, ram_q,
    output in_ready, out_data, out_valid, count,
           ram_data, ram_write_addr, ram_we, ram_read_addr
  );

  modport master (
    output in_data, in_valid, out_ready, ram_q,
    input  in_ready, out_data, out_valid, count,
           ram_data, ram_write_addr, ram_we, ram_read_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl_out_buf.sv
// Two-entry skid FIFO holding words returned by the RAM; head is presented combinationally.
module fifo_out_buf
  import ram_fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  word_t      wr_data,
  input  logic       rd_en,
  output word_t      rd_data,
  output logic [1:0] cnt
);
  word_t      mem_q [2];
  logic       wr_sel_q;
  logic       rd_sel_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) mem_q[wr_sel_q] <= wr_data;
      wr_sel_q <= wr_sel_q ^ wr_en;
      rd_sel_q <= rd_sel_q ^ rd_en;
      cnt_q    <= cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  assign rd_data = mem_q[rd_sel_q];
  assign cnt     = cnt_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO built on an external 64x8 single-port RAM with registered q.
// Reads are issued ahead so that the output buffer plus the in-flight word never exceeds two.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  bus
);
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic       inflight_q, inflight_d;
  ptr_t       ram_cnt;
  logic       full;
  logic       push;
  logic       pop;
  logic       issue;
  logic       out_valid;
  logic [1:0] buf_cnt;
  logic [2:0] occ;
  word_t      buf_data;

  assign ram_cnt   = wr_ptr_q - rd_ptr_q;
  assign full      = (ram_cnt == ptr_t'(MEM_DEPTH));
  assign push      = bus.in_valid & ~rst & ~full;
  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid & bus.out_ready;

  // buf_cnt + inflight - pop < 2, rearranged to stay unsigned
  assign occ   = {1'b0, buf_cnt} + {2'b00, inflight_q};
  assign issue = (ram_cnt != '0) & (occ < (3'd2 + {2'b00, pop}));

  assign wr_ptr_d   = wr_ptr_q + ptr_t'(push);
  assign rd_ptr_d   = rd_ptr_q + ptr_t'(issue);
  assign inflight_d = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_out_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (bus.ram_q),
    .rd_en   (pop),
    .rd_data (buf_data),
    .cnt     (buf_cnt)
  );

  assign bus.in_ready       = ~rst & ~full;
  assign bus.ram_we         = push;
  assign bus.ram_write_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_data       = bus.in_data;
  assign bus.ram_read_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = buf_data;
  assign bus.count          = cnt_t'(ram_cnt) + cnt_t'(inflight_q) + cnt_t'(buf_cnt);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural model of the 64x8 registered-output RAM.
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if bus ();

  ram_fifo_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [64];
  initial for (int k = 0; k < 64; k++) mem[k] = 8'h00;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_read_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!bus.out_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.out_data), 32'(exp));
    tick();
  endtask

  initial begin
    int accepted, sent, rcvd, first, bubbles, stalls, held;
    logic [7:0] hold;

    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_we", 32'(bus.ram_we), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // single word
    bus.in_data = 8'hAA;
    bus.in_valid = 1'b1;
    #1;
    check("single_we", 32'(bus.ram_we), 32'd1);
    check("single_waddr", 32'(bus.ram_write_addr), 32'd0);
    check("single_wdata", 32'(bus.ram_data), 32'hAA);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("single_count_e0", 32'(bus.count), 32'd1);
    check("single_valid_e0", 32'(bus.out_valid), 32'd0);
    tick();
    check("single_valid_e1", 32'(bus.out_valid), 32'd0);
    check("single_count_e1", 32'(bus.count), 32'd1);
    tick();
    check("single_valid_e2", 32'(bus.out_valid), 32'd1);
    check("single_data_e2", 32'(bus.out_data), 32'hAA);
    check("single_count_e2", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("single_valid_after_pop", 32'(bus.out_valid), 32'd0);
    check("single_count_after_pop", 32'(bus.count), 32'd0);

    // fill to full with the consumer stalled
    accepted = 0;
    for (int i = 0; i < 70; i++) begin
      bus.in_data = accepted[7:0];
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready) accepted++;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    check("fill_accepted", 32'(accepted), 32'd66);
    check("fill_count", 32'(bus.count), 32'd66);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);

    // full with simultaneous push and pop: push refused, then lands at old rd_ptr
    bus.in_data = 8'h77;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
    check("fullpop_we", 32'(bus.ram_we), 32'd0);
    check("fullpop_head", 32'(bus.out_data), 32'h00);
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("fullpop_ready_next", 32'(bus.in_ready), 32'd1);
    check("fullpop_we_next", 32'(bus.ram_we), 32'd1);
    check("fullpop_waddr", 32'(bus.ram_write_addr), 32'd3);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("fullpop_count", 32'(bus.count), 32'd66);

    bus.out_ready = 1'b1;
    for (int i = 1; i < 66; i++) pop_expect(8'(i), "fill_order");
    pop_expect(8'h77, "fill_order_last");
    bus.out_ready = 1'b0;
    #1;
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // streaming 200 words
    sent = 0; rcvd = 0; first = -1; bubbles = 0; stalls = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 260 && rcvd < 200; cyc++) begin
      bus.in_valid = (sent < 200);
      bus.in_data = sent[7:0];
      #1;
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        check("stream_data", 32'(bus.out_data), 32'(rcvd[7:0]));
        rcvd++;
      end else if (first >= 0) begin
        bubbles++;
      end
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("stream_first_cycle", 32'(first), 32'd3);
    check("stream_bubbles", 32'(bubbles), 32'd0);
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_rcvd", 32'(rcvd), 32'd200);
    check("stream_count", 32'(bus.count), 32'd0);

    // backpressure toggle over a 20-word burst
    sent = 0; rcvd = 0; held = 0; hold = 8'h00;
    for (int cyc = 0; cyc < 200 && rcvd < 20; cyc++) begin
      bus.in_valid = (sent < 20);
      bus.in_data = 8'h30 + sent[7:0];
      bus.out_ready = (cyc % 2 == 0);
      #1;
      if (held != 0) check("bp_stable", 32'(bus.out_data), 32'(hold));
      held = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check("bp_data", 32'(bus.out_data), 32'h30 + 32'(rcvd));
          rcvd++;
        end else begin
          held = 1;
          hold = bus.out_data;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("bp_rcvd", 32'(rcvd), 32'd20);
    check("bp_count", 32'(bus.count), 32'd0);

    // reset with 10 words held and a read in flight
    for (int i = 0; i < 11; i++) begin
      bus.in_data = 8'hC0 + 8'(i);
      bus.in_valid = 1'b1;
      #1;
      check("rst_push_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    check("rst_pre_count", 32'(bus.count), 32'd11);
    bus.out_ready = 1'b1;
    #1;
    check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("rst_held_count", 32'(bus.count), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_count", 32'(bus.count), 32'd0);
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_data = 8'h5C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("rst_new_valid", 32'(bus.out_valid), 32'd1);
    check("rst_new_data", 32'(bus.out_data), 32'h5C);
    check("rst_new_count", 32'(bus.count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
